serial_byte_loader: RTL and testbench

- Upstream feeder for the 8-bit load register. Receives an asynchronous, UART-style serial line: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- On each good frame, presents the assembled byte on data_out and pulses load for exactly one clock. These connect directly to the register's data_in and load.
- Frames with a bad stop bit raise frame_err and never pulse load.

---
 rtl/serial_byte_loader_if.sv | 37 +++
 rtl/serial_byte_loader.sv | 143 ++++++++++++++
 tb/tb_serial_byte_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_loader_if.sv
// serial_byte_loader_if
//   Bundles the serial line and the load-register side of the serial byte
//   loader so the design and its user share one connection point.
//   Signals:
//     rx_in     : serial line into the loader (idles high)
//     data_out  : last correctly received byte
//     load      : one-cycle strobe, data_out is new this cycle
//     frame_err : one-cycle strobe, stop bit was sampled low
//     busy      : a frame is in progress
//   Modports:
//     master : drives rx_in, observes the loader outputs
//     slave  : the loader itself
interface serial_byte_loader_if #(
    parameter int DATA_W = 8
);
    logic              rx_in;
    logic [DATA_W-1:0] data_out;
    logic              load;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx_in,
        input  data_out,
        input  load,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx_in,
        output data_out,
        output load,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/serial_byte_loader.sv
// serial_byte_loader
//   Receives a UART-style frame (start 0, DATA_W data bits LSB first,
//   stop 1) and hands each good byte to the downstream load register as
//   data_out plus a one-cycle load strobe. A low stop bit raises a
//   one-cycle frame_err instead and the loader then waits for the line to
//   return high before looking for another start bit.
//   Ports:
//     clk   : system clock, rising edge
//     reset : synchronous, active-high
//     bus   : serial_byte_loader_if.slave (rx_in, data_out, load,
//             frame_err, busy)
module serial_byte_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_byte_loader_if.slave  bus
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              load_q, load_d;
    logic              ferr_q, ferr_d;
    logic              rx_s;

    // Two-flop synchronizer; everything downstream sees rx_s only.
    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            load_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx_in};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            // Re-check the line half a bit in so a short glitch is ignored
            // and later samples land mid-bit.
            START: begin
                if (cnt_q != HALF_M1) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!rx_s) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != BIT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    shift_d[bit_q] = rx_s;
                    cnt_d          = '0;
                    if (bit_q == IDX_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != BIT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dout_d  = shift_q;
                        load_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            // A held-low break must not look like a stream of start bits.
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out  = dout_q;
    assign bus.load      = load_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_byte_loader.sv
// tb_serial_byte_loader
//   Drives serial frames into serial_byte_loader and compares every
//   load/frame_err strobe against events predicted from the frame timing
//   rules (latency from first low sample, stop-bit outcome, data held
//   between good frames).
module tb_serial_byte_loader;

    localparam int CLKS = 4;
    localparam int DW   = 8;
    localparam int HALF = CLKS / 2;
    localparam int LAT  = 2 + HALF + (DW + 1) * CLKS;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_byte_loader_if #(.DATA_W(DW)) ifc ();

    serial_byte_loader #(
        .CLKS_PER_BIT (CLKS),
        .DATA_W       (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    typedef struct {
        int          cyc;
        logic        err;
        logic [DW-1:0] data;
        logic        busy;
        logic        prev_busy;
    } ev_t;

    int   cyc   = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    // Observer: logs strobes and watches invariants every cycle.
    ev_t           obs_q[$];
    int            hold_viol     = 0;
    int            both_viol     = 0;
    int            busy_fall_cyc = -1;
    int            busy_hi_cnt   = 0;
    logic [DW-1:0] prev_dout     = '0;
    logic          prev_busy     = 1'b0;

    always @(negedge clk) begin
        if (!rst_q) begin
            if (ifc.load || ifc.frame_err)
                obs_q.push_back('{cyc, ifc.frame_err, ifc.data_out, ifc.busy, prev_busy});
            if (ifc.load && ifc.frame_err) both_viol <= both_viol + 1;
            if (!ifc.load && ifc.data_out !== prev_dout) hold_viol <= hold_viol + 1;
            if (prev_busy && !ifc.busy) busy_fall_cyc <= cyc;
            if (ifc.busy) busy_hi_cnt <= busy_hi_cnt + 1;
        end
        prev_dout <= ifc.data_out;
        prev_busy <= ifc.busy;
    end

    int            checks  = 0;
    int            errors  = 0;
    int            rd_idx  = 0;
    logic [DW-1:0] exp_dout = '0;

    // All driving happens on the falling edge; the DUT samples on rising.
    task automatic drive_bit(input logic b);
        ifc.rx_in = b;
        repeat (CLKS) @(negedge clk);
    endtask

    // s = rising edge at which the start bit is first sampled low.
    task automatic send_frame(input logic [DW-1:0] d, input logic stop, output int s);
        s = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic test_reset();
        int base;
        @(negedge clk);
        checks++; if (ifc.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h exp 00", ifc.data_out); end
        checks++; if (ifc.load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", ifc.load); end
        checks++; if (ifc.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", ifc.frame_err); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ifc.busy); end
        reset = 1'b0;
        base  = busy_hi_cnt;
        repeat (100) @(negedge clk);
        checks++; if (obs_q.size() != rd_idx) begin errors++; $display("FAIL idle_strobes got %0d exp 0", obs_q.size() - rd_idx); end
        checks++; if (busy_hi_cnt != base) begin errors++; $display("FAIL idle_busy got %0d busy cycles exp 0", busy_hi_cnt - base); end
        checks++; if (ifc.data_out !== 8'h00) begin errors++; $display("FAIL idle_data_out got %h exp 00", ifc.data_out); end
        rd_idx = obs_q.size();
    endtask

    task automatic test_good_frame();
        int s; ev_t e;
        send_frame(8'h81, 1'b1, s);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() - rd_idx != 1) begin errors++; $display("FAIL good_count got %0d exp 1", obs_q.size() - rd_idx); end
        if (obs_q.size() > rd_idx) begin
            e = obs_q[rd_idx];
            checks++; if (e.cyc != s + LAT) begin errors++; $display("FAIL good_latency got edge %0d exp %0d", e.cyc, s + LAT); end
            checks++; if (e.err !== 1'b0 || e.data !== 8'h81) begin errors++; $display("FAIL good_data got err=%b %h exp err=0 81", e.err, e.data); end
            checks++; if (e.busy !== 1'b0 || e.prev_busy !== 1'b1) begin errors++; $display("FAIL good_busy_fall got %b->%b exp 1->0", e.prev_busy, e.busy); end
        end
        exp_dout = 8'h81;
        rd_idx   = obs_q.size();
        repeat (20) @(negedge clk);
        checks++; if (ifc.data_out !== exp_dout) begin errors++; $display("FAIL good_hold got %h exp %h", ifc.data_out, exp_dout); end
    endtask

    task automatic test_back_to_back();
        int s1, s2; ev_t e0, e1;
        send_frame(8'hA5, 1'b1, s1);
        send_frame(8'h3C, 1'b1, s2);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() - rd_idx != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", obs_q.size() - rd_idx); end
        if (obs_q.size() - rd_idx >= 2) begin
            e0 = obs_q[rd_idx];
            e1 = obs_q[rd_idx + 1];
            checks++; if (e0.cyc != s1 + LAT || e0.data !== 8'hA5) begin errors++; $display("FAIL b2b_first got edge %0d %h exp %0d A5", e0.cyc, e0.data, s1 + LAT); end
            checks++; if (e1.cyc != s2 + LAT || e1.data !== 8'h3C) begin errors++; $display("FAIL b2b_second got edge %0d %h exp %0d 3C", e1.cyc, e1.data, s2 + LAT); end
            checks++; if (e1.cyc - e0.cyc != (DW + 2) * CLKS) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", e1.cyc - e0.cyc, (DW + 2) * CLKS); end
        end
        exp_dout = 8'h3C;
        rd_idx   = obs_q.size();
    endtask

    task automatic test_bad_stop();
        int s, h; ev_t e;
        send_frame(8'h55, 1'b0, s);
        ifc.rx_in = 1'b0;
        repeat (20) @(negedge clk);
        h = cyc + 1;
        ifc.rx_in = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() - rd_idx != 1) begin errors++; $display("FAIL badstop_count got %0d exp 1", obs_q.size() - rd_idx); end
        if (obs_q.size() > rd_idx) begin
            e = obs_q[rd_idx];
            checks++; if (e.err !== 1'b1 || e.cyc != s + LAT) begin errors++; $display("FAIL badstop_err got err=%b edge %0d exp 1 %0d", e.err, e.cyc, s + LAT); end
            checks++; if (e.busy !== 1'b1) begin errors++; $display("FAIL badstop_busy_at_err got %b exp 1", e.busy); end
        end
        checks++; if (ifc.data_out !== exp_dout) begin errors++; $display("FAIL badstop_data_kept got %h exp %h", ifc.data_out, exp_dout); end
        checks++; if (busy_fall_cyc != h + 2) begin errors++; $display("FAIL badstop_busy_release got edge %0d exp %0d", busy_fall_cyc, h + 2); end
        rd_idx = obs_q.size();
    endtask

    task automatic test_glitch();
        int base, hi;
        base = busy_hi_cnt;
        ifc.rx_in = 1'b0;
        @(negedge clk);
        ifc.rx_in = 1'b1;
        repeat (10) @(negedge clk);
        hi = busy_hi_cnt - base;
        checks++; if (obs_q.size() != rd_idx) begin errors++; $display("FAIL glitch_strobes got %0d exp 0", obs_q.size() - rd_idx); end
        checks++; if (hi < 1 || hi > HALF + 1) begin errors++; $display("FAIL glitch_busy_len got %0d exp 1..%0d", hi, HALF + 1); end
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got busy=%b exp 0", ifc.busy); end
        rd_idx = obs_q.size();
    endtask

    task automatic test_reset_mid();
        int s; ev_t e;
        logic [DW-1:0] d;
        d = 8'hF0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        ifc.rx_in = d[4];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ifc.busy !== 1'b0 || ifc.data_out !== 8'h00) begin errors++; $display("FAIL midreset_clear got busy=%b %h exp 0 00", ifc.busy, ifc.data_out); end
        reset    = 1'b0;
        exp_dout = '0;
        repeat (CLKS - 2) @(negedge clk);
        for (int i = 5; i < DW; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        repeat (8) @(negedge clk);
        checks++; if (obs_q.size() != rd_idx) begin errors++; $display("FAIL midreset_aborted got %0d strobes exp 0", obs_q.size() - rd_idx); end
        rd_idx = obs_q.size();
        send_frame(8'h0F, 1'b1, s);
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() - rd_idx != 1) begin errors++; $display("FAIL midreset_next_count got %0d exp 1", obs_q.size() - rd_idx); end
        if (obs_q.size() > rd_idx) begin
            e = obs_q[rd_idx];
            checks++; if (e.err !== 1'b0 || e.data !== 8'h0F || e.cyc != s + LAT) begin errors++; $display("FAIL midreset_next got err=%b %h edge %0d exp 0 0F %0d", e.err, e.data, e.cyc, s + LAT); end
        end
        exp_dout = 8'h0F;
        rd_idx   = obs_q.size();
    endtask

    task automatic test_random();
        int exp_cyc[$]; logic exp_err[$]; logic [DW-1:0] exp_dat[$];
        int s, gap, n; logic bad; logic [DW-1:0] d; ev_t e;
        for (int k = 0; k < 12; k++) begin
            d   = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_frame(d, !bad, s);
            exp_cyc.push_back(s + LAT);
            exp_err.push_back(bad);
            if (!bad) exp_dout = d;
            exp_dat.push_back(exp_dout);
            gap = bad ? 1 + $urandom_range(0, 1) : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        repeat (6) @(negedge clk);
        n = obs_q.size() - rd_idx;
        checks++; if (n != exp_cyc.size()) begin errors++; $display("FAIL rand_count got %0d exp %0d", n, exp_cyc.size()); end
        for (int k = 0; k < n && k < exp_cyc.size(); k++) begin
            e = obs_q[rd_idx + k];
            checks++;
            if (e.cyc != exp_cyc[k] || e.err !== exp_err[k] || e.data !== exp_dat[k]) begin
                errors++;
                $display("FAIL rand_ev%0d got edge %0d err=%b %h exp %0d %b %h", k, e.cyc, e.err, e.data, exp_cyc[k], exp_err[k], exp_dat[k]);
            end
        end
        checks++; if (ifc.data_out !== exp_dout) begin errors++; $display("FAIL rand_final_data got %h exp %h", ifc.data_out, exp_dout); end
        rd_idx = obs_q.size();
    endtask

    initial begin
        ifc.rx_in = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_bad_stop();
        test_glitch();
        test_reset_mid();
        test_random();
        checks++; if (hold_viol != 0) begin errors++; $display("FAIL data_hold got %0d changes without load exp 0", hold_viol); end
        checks++; if (both_viol != 0) begin errors++; $display("FAIL strobe_overlap got %0d exp 0", both_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
